wet_dry_mixer: RTL and testbench
================================

Name: wet_dry_mixer

Overview:
- Downstream of the chorus/delay effect chain.
- Blends the dry input sample with the wet (effected) sample: out = dry·(1−g) + wet·g.
- g ramps toward a requested mix level by a fixed step per audio sample, so level changes and enable toggles never produce zipper noise or clicks.
- Output feeds the DAC/output serializer stage at the audio sample rate; core clock is 11.29 MHz.

Parameters:
- WIDTH, 16, signed audio sample width.
- MIX_WIDTH, 8, gain fraction bits; unity gain = 2^MIX_WIDTH (256).
- RAMP_STEP, 4, gain change per accepted sample, in LSBs.

Ports:
- clk_in  input  1  system clock, 11.29 MHz.
- rst_in  input  1  synchronous, active-high reset.
- sample_valid_in  input  1  one-cycle strobe; data_dry/data_wet valid this cycle.
- data_dry  input  WIDTH  signed dry sample.
- data_wet  input  WIDTH  signed wet sample (chorus output).
- mix_enable  input  1  when low, target gain is forced to 0 (dry only).
- mix_level  input  MIX_WIDTH+1  requested wet gain, 0..256; values above 256 clamp to 256.
- data_out  output  WIDTH  signed mixed sample.
- sample_valid_out  output  1  one-cycle strobe qualifying data_out.
- ramp_busy  output  1  high while current gain ≠ target gain.

Behaviour:
- Interface: one clock, clk_in. Reset rst_in is synchronous and active-high.
- Reset values: data_out=0, sample_valid_out=0, ramp_busy=0, current gain g=0, all pipeline registers and valids=0, FSM=SETTLED.
- Target: tgt = mix_enable ? min(mix_level, 256) : 0. It is evaluated every cycle (combinational from inputs).
- FSM states:
  - SETTLED (g==tgt) and RAMPING (g≠tgt).
  - Transition to RAMPING is registered the cycle after tgt differs from g.
  - Transition to SETTLED happens on the cycle g reaches tgt.
  - ramp_busy = (state==RAMPING).
- Gain update occurs only on cycles with sample_valid_in=1:
  - g<tgt → g = min(g+RAMP_STEP, tgt).
  - g>tgt → g = max(g−RAMP_STEP, tgt).
  - Never overshoot. g stays within 0..256 at all times.
- Per-sample gain: a sample uses the g value held in the cycle it is accepted (pre-update). The update takes effect for the next sample.
- tgt changing mid-ramp: direction re-evaluated on the next accepted sample. No restart, no jump.
- Pipeline, fixed latency 3 cycles from sample_valid_in to sample_valid_out. Back-to-back strobes (every cycle) are supported.
  - S1: register dry, wet, g.
  - S2: p = dry·(256−g) + wet·g. Signed, width WIDTH+MIX_WIDTH+2.
  - S3: r = (p + 2^(MIX_WIDTH−1)) >>> MIX_WIDTH (arithmetic shift, round half up). Saturate to [−2^(WIDTH−1), 2^(WIDTH−1)−1]. Register to data_out.
- data_out holds its last value between strobes. sample_valid_out is high for exactly one cycle per input strobe.
- Exactness: g=0 gives data_out==data_dry; g=256 gives data_out==data_wet, bit-exact.
- Reset mid-operation: pipeline flushed. No sample_valid_out pulses for samples accepted before reset. g returns to 0 immediately, with no ramp.
- sample_valid_in asserted together with rst_in: ignored.

Decomposition:
- Package effect_pkg holds:
  - MIX_WIDTH default and UNITY_GAIN constant.
  - typedef enum mix_state_t {SETTLED, RAMPING}.
  - typedef for signed sample (logic signed [WIDTH-1:0]), shared with the delay/chorus blocks.
- One sub-module, gain_ramp:
  - Contains the g register, target clamp, step/clamp logic and FSM.
  - Outputs g and ramp_busy.
  - The mixer top holds the 3-stage datapath.

Test Plan:
- Reset, then mix_enable=0, dry=1000, wet=−2000, one strobe → sample_valid_out 3 cycles later; data_out=1000; ramp_busy=0.
- mix_enable=1, mix_level=256, dry=1000, wet=−2000, strobes every 256 cycles:
  - g steps 0,4,…,256 over 64 samples; ramp_busy drops once g=256.
  - Sample 65 onward: data_out=−2000.
  - At g=128 (sample 33): data_out=−500.
- Boundary, g=256, dry=32767, wet=−32768 → −32768. g=128, dry=wet=32767 → 32767 (no overflow). dry=1, wet=0, g=128 → 1 (round half up).
- mix_level=300 → clamps to 256. Mid-ramp at g=100, drop mix_level to 0 → next samples g=96,92,…; never negative; settles at 0.
- Strobes every cycle for 20 cycles → 20 sample_valid_out pulses, each 3 cycles after its input, values matching the reference model. Assert rst_in during the stream → no further pulses; data_out=0; g=0.

Source files
------------

// File: rtl/effect_pkg.sv
// Shared types and constants for the effect chain (delay, chorus, wet/dry mixer).
package effect_pkg;

  localparam int unsigned MIX_WIDTH_DEFAULT = 8;
  localparam int unsigned UNITY_GAIN        = 1 << MIX_WIDTH_DEFAULT;
  localparam int unsigned SAMPLE_WIDTH      = 16;

  typedef enum logic [0:0] {
    SETTLED,
    RAMPING
  } mix_state_t;

  typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

endpackage

// File: rtl/gain_ramp.sv
// Wet-gain ramp: slews the current gain toward the clamped target by a fixed
// step on each accepted sample, flagging busy while the two differ.
module gain_ramp
  import effect_pkg::*;
#(
  parameter int unsigned MIX_WIDTH = MIX_WIDTH_DEFAULT,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               sample_valid_in,
  input  logic               mix_enable,
  input  logic [MIX_WIDTH:0] mix_level,
  output logic [MIX_WIDTH:0] gain_o,
  output logic               ramp_busy_o
);

  localparam logic [MIX_WIDTH:0] Unity = (MIX_WIDTH + 1)'(1 << MIX_WIDTH);
  localparam logic [MIX_WIDTH:0] Step  = (MIX_WIDTH + 1)'(RAMP_STEP);

  logic [MIX_WIDTH:0] tgt;
  logic [MIX_WIDTH:0] g_d, g_q;
  mix_state_t         state_d, state_q;

  // Distances are compared before stepping, so the sum never exceeds tgt and
  // the difference never wraps below it.
  always_comb begin
    tgt = '0;
    if (mix_enable) begin
      tgt = (mix_level > Unity) ? Unity : mix_level;
    end
    g_d = g_q;
    if (sample_valid_in) begin
      if (g_q < tgt) begin
        g_d = (tgt - g_q > Step) ? g_q + Step : tgt;
      end else if (g_q > tgt) begin
        g_d = (g_q - tgt > Step) ? g_q - Step : tgt;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      SETTLED: if (g_d != tgt) state_d = RAMPING;
      RAMPING: if (g_d == tgt) state_d = SETTLED;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      g_q     <= '0;
      state_q <= SETTLED;
    end else begin
      g_q     <= g_d;
      state_q <= state_d;
    end
  end

  assign gain_o      = g_q;
  assign ramp_busy_o = (state_q == RAMPING);

endmodule

// File: rtl/wet_dry_mixer.sv
// Wet/dry crossfade: out = dry*(1-g) + wet*g through a fixed 3-stage pipeline,
// with g slewed by gain_ramp to avoid zipper noise.
module wet_dry_mixer
  import effect_pkg::*;
#(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned MIX_WIDTH = MIX_WIDTH_DEFAULT,
  parameter int unsigned RAMP_STEP = 4
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    sample_valid_in,
  input  logic signed [WIDTH-1:0] data_dry,
  input  logic signed [WIDTH-1:0] data_wet,
  input  logic                    mix_enable,
  input  logic [MIX_WIDTH:0]      mix_level,
  output logic signed [WIDTH-1:0] data_out,
  output logic                    sample_valid_out,
  output logic                    ramp_busy
);

  localparam int unsigned        PW     = WIDTH + MIX_WIDTH + 2;
  localparam logic [MIX_WIDTH:0] Unity  = (MIX_WIDTH + 1)'(1 << MIX_WIDTH);
  localparam logic signed [PW-1:0] Half   = PW'(1 << (MIX_WIDTH - 1));
  localparam logic signed [PW-1:0] SatMax = PW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [PW-1:0] SatMin = ~SatMax;

  logic [MIX_WIDTH:0] gain;

  gain_ramp #(
    .MIX_WIDTH (MIX_WIDTH),
    .RAMP_STEP (RAMP_STEP)
  ) u_gain_ramp (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sample_valid_in (sample_valid_in),
    .mix_enable      (mix_enable),
    .mix_level       (mix_level),
    .gain_o          (gain),
    .ramp_busy_o     (ramp_busy)
  );

  logic                    v1_d, v1_q, v2_d, v2_q, vout_d, vout_q;
  logic signed [WIDTH-1:0] dry1_d, dry1_q, wet1_d, wet1_q, dout_d, dout_q;
  logic [MIX_WIDTH:0]      g1_d, g1_q;
  logic signed [PW-1:0]    p2_d, p2_q;
  logic signed [PW-1:0]    dry_x, wet_x, gw_x, dw_x, rnd_sum, rnd_shr;

  always_comb begin
    // S1: capture the sample with the gain held this cycle (pre-update).
    v1_d   = sample_valid_in;
    dry1_d = data_dry;
    wet1_d = data_wet;
    g1_d   = gain;

    // S2: weighted sum; weights are non-negative so zero-extend them.
    dry_x = {{(PW - WIDTH){dry1_q[WIDTH-1]}}, dry1_q};
    wet_x = {{(PW - WIDTH){wet1_q[WIDTH-1]}}, wet1_q};
    gw_x  = $signed({{(PW - MIX_WIDTH - 1){1'b0}}, g1_q});
    dw_x  = $signed({{(PW - MIX_WIDTH - 1){1'b0}}, Unity - g1_q});
    v2_d  = v1_q;
    p2_d  = dry_x * dw_x + wet_x * gw_x;

    // S3: round half up, then saturate into the sample range.
    rnd_sum = p2_q + Half;
    rnd_shr = rnd_sum >>> MIX_WIDTH;
    vout_d  = v2_q;
    dout_d  = dout_q;
    if (v2_q) begin
      if (rnd_shr > SatMax) begin
        dout_d = SatMax[WIDTH-1:0];
      end else if (rnd_shr < SatMin) begin
        dout_d = SatMin[WIDTH-1:0];
      end else begin
        dout_d = rnd_shr[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      v1_q   <= 1'b0;
      dry1_q <= '0;
      wet1_q <= '0;
      g1_q   <= '0;
      v2_q   <= 1'b0;
      p2_q   <= '0;
      vout_q <= 1'b0;
      dout_q <= '0;
    end else begin
      v1_q   <= v1_d;
      dry1_q <= dry1_d;
      wet1_q <= wet1_d;
      g1_q   <= g1_d;
      v2_q   <= v2_d;
      p2_q   <= p2_d;
      vout_q <= vout_d;
      dout_q <= dout_d;
    end
  end

  assign data_out         = dout_q;
  assign sample_valid_out = vout_q;

endmodule

// File: tb/tb_wet_dry_mixer.sv
// Self-checking bench for wet_dry_mixer: directed plan plus random traffic,
// every cycle compared against a sample-level reference model.
module tb_wet_dry_mixer;

  logic               clk = 1'b0;
  logic               rst_in = 1'b1;
  logic               valid = 1'b0;
  logic               en = 1'b0;
  logic signed [15:0] dry = '0;
  logic signed [15:0] wet = '0;
  logic [8:0]         lvl = '0;
  logic signed [15:0] data_out;
  logic               vout;
  logic               busy;

  always #5 clk = ~clk;

  wet_dry_mixer #(
    .WIDTH     (16),
    .MIX_WIDTH (8),
    .RAMP_STEP (4)
  ) dut (
    .clk_in           (clk),
    .rst_in           (rst_in),
    .sample_valid_in  (valid),
    .data_dry         (dry),
    .data_wet         (wet),
    .mix_enable       (en),
    .mix_level        (lvl),
    .data_out         (data_out),
    .sample_valid_out (vout),
    .ramp_busy        (busy)
  );

  int vectors = 0;
  int miscompares = 0;
  int edge_n = 0;
  int pulses = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int g_m = 0;
  int last_m = 0;
  bit vout_m = 1'b0;
  bit busy_m = 1'b0;
  typedef struct {int due; int val;} exp_t;
  exp_t exp_q[$];

  function automatic int mix(int d, int w, int g);
    int p;
    int r;
    p = d * (256 - g) + w * g;
    r = (p + 128) >>> 8;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r;
  endfunction

  task automatic check(string name, int got, int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s at edge %0d: got %0d, expected %0d", name, edge_n, got, exp);
    end
  endtask

  // Advance one clock; the model consumes the inputs seen at that edge.
  task automatic cyc();
    int   tgt;
    exp_t e;
    @(posedge clk);
    if (rst_in) begin
      g_m    = 0;
      busy_m = 1'b0;
      last_m = 0;
      exp_q.delete();
    end else begin
      tgt = en ? ((int'(lvl) > 256) ? 256 : int'(lvl)) : 0;
      if (valid) begin
        e.due = edge_n + 2;
        e.val = mix(int'(dry), int'(wet), g_m);
        exp_q.push_back(e);
        if (g_m < tgt) g_m = (g_m + 4 > tgt) ? tgt : g_m + 4;
        else if (g_m > tgt) g_m = (g_m - 4 < tgt) ? tgt : g_m - 4;
      end
      busy_m = (g_m != tgt);
    end
    vout_m = 1'b0;
    if (!rst_in && exp_q.size() > 0 && exp_q[0].due == edge_n) begin
      vout_m = 1'b1;
      last_m = exp_q[0].val;
      void'(exp_q.pop_front());
    end
    edge_n++;
    #1;
  endtask

  task automatic strobe(int d, int w);
    dry   = 16'(d);
    wet   = 16'(w);
    valid = 1'b1;
    cyc();
    valid = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic strobe_check(string name, int d, int w, int exp);
    strobe(d, w);
    check({name, " valid"}, int'(vout), 1);
    check(name, int'(data_out), exp);
  endtask

  always @(negedge clk) begin
    if (vout) pulses++;
    if (chk_en) begin
      check("valid_out", int'(vout), int'(vout_m));
      check("data_out", int'(data_out), last_m);
      check("ramp_busy", int'(busy), int'(busy_m));
    end
  end

  initial begin
    rst_in = 1'b1;
    cyc();
    cyc();
    chk_en = 1'b1;
    check("reset data_out", int'(data_out), 0);
    check("reset valid_out", int'(vout), 0);
    check("reset busy", int'(busy), 0);
    rst_in = 1'b0;
    cyc();

    // Dry only.
    en = 1'b0;
    strobe_check("dry only", 1000, -2000, 1000);
    check("dry only busy", int'(busy), 0);

    // Full ramp to unity, one sample every 256 cycles.
    en  = 1'b1;
    lvl = 9'd256;
    cyc();
    check("ramp start busy", int'(busy), 1);
    for (int n = 1; n <= 70; n++) begin
      strobe(1000, -2000);
      if (n == 33) check("g=128 mix", int'(data_out), -500);
      if (n == 63) check("busy before top", int'(busy), 1);
      if (n == 64) check("busy at top", int'(busy), 0);
      if (n == 65 || n == 70) check("g=256 wet", int'(data_out), -2000);
      repeat (253) cyc();
    end

    strobe_check("g=256 extreme", 32767, -32768, -32768);

    // Ramp down to half gain.
    lvl = 9'd128;
    for (int k = 0; k < 100 && g_m != 128; k++) begin
      dry   = 16'($urandom());
      wet   = 16'($urandom());
      valid = 1'b1;
      cyc();
      valid = 1'b0;
      cyc();
    end
    repeat (3) cyc();
    check("half settled busy", int'(busy), 0);
    strobe_check("g=128 no overflow", 32767, 32767, 32767);
    strobe_check("g=128 round half up", 1, 0, 1);

    // Level above unity clamps to 256.
    lvl = 9'd300;
    for (int k = 0; k < 100 && g_m != 256; k++) strobe(3, 4);
    cyc();
    check("clamp busy", int'(busy), 0);
    strobe_check("clamp wet exact", 5, -7, -7);

    // Mid-ramp reversal at g=100.
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    lvl    = 9'd300;
    repeat (25) strobe(0, 1000);
    lvl = 9'd0;
    strobe_check("reverse g=100", 0, 1000, 391);
    strobe_check("reverse g=96", 0, 1000, 375);
    repeat (30) strobe(0, 1000);
    check("reverse settled busy", int'(busy), 0);
    strobe_check("reverse g=0", 0, 1000, 0);

    // Back-to-back burst of 20.
    lvl = 9'($urandom_range(0, 300));
    repeat (3) cyc();
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      dry   = 16'($urandom());
      wet   = 16'($urandom());
      valid = 1'b1;
      cyc();
    end
    valid = 1'b0;
    repeat (5) cyc();
    check("burst pulses", pulses, 20);

    // Reset in the middle of a stream.
    lvl = 9'd256;
    for (int i = 0; i < 6; i++) begin
      dry    = 16'($urandom());
      wet    = 16'($urandom());
      valid  = 1'b1;
      rst_in = (i == 5);
      cyc();
    end
    rst_in = 1'b0;
    valid  = 1'b0;
    pulses = 0;
    repeat (6) cyc();
    check("post-reset pulses", pulses, 0);
    check("post-reset data_out", int'(data_out), 0);
    strobe_check("post-reset g=0", 500, 9000, 500);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      valid = ($urandom() % 2) == 0;
      dry   = 16'($urandom());
      wet   = 16'($urandom());
      if ($urandom() % 32 == 0) begin
        en  = ($urandom() % 4) != 0;
        lvl = 9'($urandom_range(0, 320));
      end
      rst_in = ($urandom() % 200) == 0;
      cyc();
    end
    rst_in = 1'b0;
    valid  = 1'b0;
    repeat (5) cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
